// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array operand loader:
//   - state_t : loader FSM state encoding
//   - cnt_w() : width of the per-stream read counters
// -----------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        FIRE  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    // Counter must hold the longest stream length, max(X,Y)*N, inclusive.
    function automatic int unsigned cnt_w(input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned n);
        int unsigned m;
        m = (x > y) ? x : y;
        return $clog2(m * n + 1);
    endfunction

endpackage

// File: rtl/sa_stream_reader.sv
// -----------------------------------------------------------------------------
// sa_stream_reader
// Reads LEN consecutive operand words starting at a latched base address,
// one read per cycle, and replays the returned data as a valid-qualified
// beat stream two cycles behind the read strobe.
// Ports:
//   clk, sys_rst   : clock, synchronous active-high reset
//   i_launch       : start a new burst (base is latched, first read issued)
//   i_base         : burst base address
//   i_rd_data      : memory read data, valid one cycle after o_rd_en
//   o_rd_en/o_addr : memory read strobe and address
//   o_val/o_data   : output beat stream
//   o_last_c       : all LEN reads of the current burst have been issued
// -----------------------------------------------------------------------------
module sa_stream_reader #(
    parameter int unsigned LEN    = 12,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned MEM_AW = 8,
    parameter int unsigned IN_LEN = 8
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              i_launch,
    input  logic [MEM_AW-1:0] i_base,
    input  logic [IN_LEN-1:0] i_rd_data,
    output logic              o_rd_en,
    output logic [MEM_AW-1:0] o_addr,
    output logic              o_val,
    output logic [IN_LEN-1:0] o_data,
    output logic              o_last_c
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    logic [CNT_W-1:0]  r_cnt;      // reads issued in the current burst
    logic [MEM_AW-1:0] r_base;
    logic              r_rd_en_d1; // marks the cycle memory data is valid

    assign o_last_c = (r_cnt == LEN_C);

    // Read issue, address generation and 2-stage valid/data pipeline.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_cnt      <= '0;
            r_base     <= '0;
            r_rd_en_d1 <= 1'b0;
            o_rd_en    <= 1'b0;
            o_addr     <= '0;
            o_val      <= 1'b0;
            o_data     <= '0;
        end else begin
            r_rd_en_d1 <= o_rd_en;
            o_val      <= r_rd_en_d1;
            // Data is only captured on beats it belongs to, so nothing stale
            // leaks onto the stream between bursts.
            o_data     <= r_rd_en_d1 ? i_rd_data : '0;

            if (i_launch) begin
                r_base  <= i_base;
                r_cnt   <= CNT_W'(1);
                o_rd_en <= 1'b1;
                o_addr  <= i_base;
            end else if (o_rd_en) begin
                if (r_cnt < LEN_C) begin
                    // Address wraps modulo 2^MEM_AW by truncation.
                    o_addr <= r_base + MEM_AW'(r_cnt);
                    r_cnt  <= r_cnt + CNT_W'(1);
                end else begin
                    o_rd_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sa_operand_loader.sv
// -----------------------------------------------------------------------------
// sa_operand_loader
// Feeds a systolic array: on start, streams matrix A (X rows x N, row-major)
// and matrix B (N x Y columns, column-major) from two operand memories onto
// the array's X/Y input streams, pulses SA_start once both bursts have
// drained, then waits for the array's sa_done before signalling done.
// Ports:
//   clk, sys_rst                  : clock, synchronous active-high reset
//   start, x_base, y_base         : load request and operand base addresses
//   sa_done                       : array completion pulse
//   busy, done                    : loader status / completion pulse
//   xmem_rd_en/addr/rd_data       : A operand memory read port
//   ymem_rd_en/addr/rd_data       : B operand memory read port
//   Xin_val/Xin_data              : X-side beat stream to the array
//   Yin_val/Yin_data              : Y-side beat stream to the array
//   SA_start                      : array launch pulse
// -----------------------------------------------------------------------------
module sa_operand_loader
    import sa_pkg::*;
#(
    parameter int unsigned X      = 3,
    parameter int unsigned N      = 4,
    parameter int unsigned Y      = 3,
    parameter int unsigned IN_LEN = 8,
    parameter int unsigned MEM_AW = 8
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [MEM_AW-1:0] x_base,
    input  logic [MEM_AW-1:0] y_base,
    input  logic              sa_done,
    output logic              busy,
    output logic              done,
    output logic              xmem_rd_en,
    output logic [MEM_AW-1:0] xmem_addr,
    input  logic [IN_LEN-1:0] xmem_rd_data,
    output logic              ymem_rd_en,
    output logic [MEM_AW-1:0] ymem_addr,
    input  logic [IN_LEN-1:0] ymem_rd_data,
    output logic              Xin_val,
    output logic [IN_LEN-1:0] Xin_data,
    output logic              Yin_val,
    output logic [IN_LEN-1:0] Yin_data,
    output logic              SA_start
);

    localparam int unsigned CNT_W = cnt_w(X, Y, N);

    state_t r_state;
    logic   r_drain;     // second DRAIN cycle marker
    logic   w_launch;
    logic   w_x_last;
    logic   w_y_last;

    assign w_launch = (r_state == IDLE) && start;

    sa_stream_reader #(
        .LEN    (X * N),
        .CNT_W  (CNT_W),
        .MEM_AW (MEM_AW),
        .IN_LEN (IN_LEN)
    ) u_x_reader (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .i_launch  (w_launch),
        .i_base    (x_base),
        .i_rd_data (xmem_rd_data),
        .o_rd_en   (xmem_rd_en),
        .o_addr    (xmem_addr),
        .o_val     (Xin_val),
        .o_data    (Xin_data),
        .o_last_c  (w_x_last)
    );

    sa_stream_reader #(
        .LEN    (Y * N),
        .CNT_W  (CNT_W),
        .MEM_AW (MEM_AW),
        .IN_LEN (IN_LEN)
    ) u_y_reader (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .i_launch  (w_launch),
        .i_base    (y_base),
        .i_rd_data (ymem_rd_data),
        .o_rd_en   (ymem_rd_en),
        .o_addr    (ymem_addr),
        .o_val     (Yin_val),
        .o_data    (Yin_data),
        .o_last_c  (w_y_last)
    );

    // Loader FSM with registered status/launch outputs.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_state  <= IDLE;
            r_drain  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            SA_start <= 1'b0;
        end else begin
            done     <= 1'b0;
            SA_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy stays up through the done cycle, then follows start.
                    busy <= start;
                    if (start) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_drain <= 1'b0;
                    if (w_x_last && w_y_last) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Two cycles: the last read's data and its beat register.
                    if (r_drain) begin
                        r_state  <= FIRE;
                        SA_start <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                FIRE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (sa_done) begin
                        r_state <= IDLE;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sa_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_sa_operand_loader
// Two loaders share the same control inputs: dut_a uses X=Y=3, N=4 and
// dut_b uses X=3, Y=1, N=4 (both have a 12-beat longest stream). Each has
// its own operand memories whose contents equal their address.
// -----------------------------------------------------------------------------
module tb_sa_operand_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst;
    logic       start;
    logic       sa_done;
    logic [7:0] x_base;
    logic [7:0] y_base;

    logic       a_busy, a_done, a_xen, a_yen, a_xval, a_yval, a_sa;
    logic [7:0] a_xaddr, a_yaddr, a_xrd, a_yrd, a_xdata, a_ydata;
    logic       b_busy, b_done, b_xen, b_yen, b_xval, b_yval, b_sa;
    logic [7:0] b_xaddr, b_yaddr, b_xrd, b_yrd, b_xdata, b_ydata;

    int errors = 0;
    int checks = 0;

    sa_operand_loader #(.X(3), .N(4), .Y(3), .IN_LEN(8), .MEM_AW(8)) dut_a (
        .clk(clk), .sys_rst(sys_rst), .start(start), .x_base(x_base),
        .y_base(y_base), .sa_done(sa_done), .busy(a_busy), .done(a_done),
        .xmem_rd_en(a_xen), .xmem_addr(a_xaddr), .xmem_rd_data(a_xrd),
        .ymem_rd_en(a_yen), .ymem_addr(a_yaddr), .ymem_rd_data(a_yrd),
        .Xin_val(a_xval), .Xin_data(a_xdata), .Yin_val(a_yval),
        .Yin_data(a_ydata), .SA_start(a_sa)
    );

    sa_operand_loader #(.X(3), .N(4), .Y(1), .IN_LEN(8), .MEM_AW(8)) dut_b (
        .clk(clk), .sys_rst(sys_rst), .start(start), .x_base(x_base),
        .y_base(y_base), .sa_done(sa_done), .busy(b_busy), .done(b_done),
        .xmem_rd_en(b_xen), .xmem_addr(b_xaddr), .xmem_rd_data(b_xrd),
        .ymem_rd_en(b_yen), .ymem_addr(b_yaddr), .ymem_rd_data(b_yrd),
        .Xin_val(b_xval), .Xin_data(b_xdata), .Yin_val(b_yval),
        .Yin_data(b_ydata), .SA_start(b_sa)
    );

    // Registered-read operand memories: word content equals its address.
    always @(posedge clk) begin
        if (a_xen) a_xrd <= a_xaddr;
        if (a_yen) a_yrd <= a_yaddr;
        if (b_xen) b_xrd <= b_xaddr;
        if (b_yen) b_yrd <= b_yaddr;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"}, {a_busy, a_done, a_xen, a_xaddr, a_yen, a_yaddr,
                          a_xval, a_xdata, a_yval, a_ydata, a_sa}, 64'd0);
        chk({tag, "_b"}, {b_busy, b_done, b_xen, b_xaddr, b_yen, b_yaddr,
                          b_xval, b_xdata, b_yval, b_ydata, b_sa}, 64'd0);
    endtask

    // Called at a negedge in IDLE; start is driven in this cycle (cycle t).
    // Returns at the negedge of cycle t+16, with both loaders in WAIT.
    task automatic load_check(input logic [7:0] xb, input logic [7:0] yb,
                              input bit repulse);
        chk("idle_busy_a", a_busy, 0);
        chk("idle_busy_b", b_busy, 0);
        start  = 1'b1;
        x_base = xb;
        y_base = yb;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = (repulse && k == 5);
            if (k == 1) begin
                x_base = 8'h55;   // bases must have been latched already
                y_base = 8'h66;
            end
            chk("busy_a", a_busy, 1);
            chk("busy_b", b_busy, 1);
            chk("xen_a", a_xen, (k <= 12));
            chk("yen_a", a_yen, (k <= 12));
            chk("xen_b", b_xen, (k <= 12));
            chk("yen_b", b_yen, (k <= 4));
            if (k <= 12) begin
                chk("xaddr_a", a_xaddr, 8'(xb + k - 1));
                chk("yaddr_a", a_yaddr, 8'(yb + k - 1));
                chk("xaddr_b", b_xaddr, 8'(xb + k - 1));
            end
            if (k <= 4) chk("yaddr_b", b_yaddr, 8'(yb + k - 1));
            chk("xval_a", a_xval, (k >= 3 && k <= 14));
            chk("yval_a", a_yval, (k >= 3 && k <= 14));
            chk("xval_b", b_xval, (k >= 3 && k <= 14));
            chk("yval_b", b_yval, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 14) begin
                chk("xdata_a", a_xdata, 8'(xb + k - 3));
                chk("ydata_a", a_ydata, 8'(yb + k - 3));
                chk("xdata_b", b_xdata, 8'(xb + k - 3));
            end
            if (k >= 3 && k <= 6) chk("ydata_b", b_ydata, 8'(yb + k - 3));
            chk("sa_start_a", a_sa, (k == 15));
            chk("sa_start_b", b_sa, (k == 15));
        end
    endtask

    // Called at the negedge of cycle t+16 (WAIT). sa_done is raised in
    // cycle t+17, optionally together with start.
    task automatic finish_wait(input bit with_start, input bit repulse_wait);
        start = repulse_wait;
        @(negedge clk);
        start = 1'b0;
        chk("wait_sa_a", a_sa, 0);
        chk("wait_sa_b", b_sa, 0);
        chk("wait_busy_a", a_busy, 1);
        chk("wait_done_a", a_done, 0);
        chk("wait_xen_a", a_xen, 0);
        sa_done = 1'b1;
        start   = with_start;
        @(negedge clk);
        sa_done = 1'b0;
        start   = 1'b0;
        chk("done_a", a_done, 1);
        chk("done_b", b_done, 1);
        chk("done_busy_a", a_busy, 1);
        chk("done_busy_b", b_busy, 1);
        chk("done_xen_a", a_xen, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_done_a", a_done, 0);
            chk("post_busy_a", a_busy, 0);
            chk("post_busy_b", b_busy, 0);
            chk("post_xen_a", a_xen, 0);
            chk("post_yen_b", b_yen, 0);
            chk("post_sa_a", a_sa, 0);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        start   = 1'b0;
        sa_done = 1'b0;
        x_base  = 8'h00;
        y_base  = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        sys_rst = 1'b0;
        // sa_done outside WAIT must be ignored.
        sa_done = 1'b1;
        @(negedge clk);
        sa_done = 1'b0;
        check_all_zero("idle_sa_done");
        @(negedge clk);

        // Basic load: A at 0, B at 0x20.
        load_check(8'h00, 8'h20, 1'b0);
        finish_wait(1'b0, 1'b0);

        // Address wrap, start re-pulsed during LOAD and in WAIT.
        load_check(8'hFE, 8'hF8, 1'b1);
        finish_wait(1'b0, 1'b1);

        // Reset in the middle of a load.
        start  = 1'b1;
        x_base = 8'h10;
        y_base = 8'h40;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 6) begin
                chk("pre_rst_xen_a", a_xen, 1);
                chk("pre_rst_xaddr_a", a_xaddr, 8'h15);
                sys_rst = 1'b1;
            end
            if (k == 7) begin
                check_all_zero("mid_rst");
                sys_rst = 1'b0;
            end
            if (k == 8) check_all_zero("after_rst");
        end
        @(negedge clk);
        load_check(8'h30, 8'h50, 1'b0);
        // start together with sa_done in WAIT is not accepted.
        finish_wait(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
